// File: rtl/immed_pkg.sv
// Shared immediate-code definitions used by the constant encoder and the ALU immediate LUT.
// imm_value() is the single place that defines what each 3-bit code adds.
package immed_pkg;

    localparam logic [2:0] IMM_ZERO = 3'b000;
    localparam logic [2:0] IMM_P1   = 3'b001;
    localparam logic [2:0] IMM_P2   = 3'b010;
    localparam logic [2:0] IMM_P4   = 3'b011;
    localparam logic [2:0] IMM_P8   = 3'b100;
    localparam logic [2:0] IMM_M1   = 3'b101;
    localparam logic [2:0] IMM_M2   = 3'b110;
    localparam logic [2:0] IMM_M4   = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    // Two's-complement 8-bit value added to the register by each immediate code.
    function automatic logic [7:0] imm_value(input logic [2:0] code);
        logic [7:0] val;
        case (code)
            IMM_ZERO: val = 8'h00;
            IMM_P1:   val = 8'h01;
            IMM_P2:   val = 8'h02;
            IMM_P4:   val = 8'h04;
            IMM_P8:   val = 8'h08;
            IMM_M1:   val = 8'hFF;
            IMM_M2:   val = 8'hFE;
            default:  val = 8'hFC;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/immed_step_sel.sv
// Greedy step picker: chooses the largest-magnitude immediate that does not
// overshoot the signed residual, and reports the value that code adds.
module immed_step_sel
    import immed_pkg::*;
(
    input  logic [7:0] residual,
    output logic [2:0] code,
    output logic [7:0] step_val
);

    logic signed [7:0] r_s;

    assign r_s = residual;

    always_comb begin
        code = IMM_ZERO;
        if (r_s >= 8'sd8) begin
            code = IMM_P8;
        end else if (r_s >= 8'sd4) begin
            code = IMM_P4;
        end else if (r_s >= 8'sd2) begin
            code = IMM_P2;
        end else if (r_s == 8'sd1) begin
            code = IMM_P1;
        end else if (r_s == 8'sd0) begin
            code = IMM_ZERO;
        end else if (r_s == -8'sd1) begin
            code = IMM_M1;
        end else if (r_s >= -8'sd3) begin
            code = IMM_M2;
        end else begin
            code = IMM_M4;
        end
    end

    // Value comes from the shared table so the encoder can never disagree with the LUT.
    assign step_val = imm_value(code);

endmodule

// File: rtl/immed_encoder.sv
// Turns a (base, target) pair into a stream of 3-bit add-immediate codes whose
// sum, in 8-bit wrap arithmetic, moves base onto target.
module immed_encoder
    import immed_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CW    = 3,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    base_val,
    input  logic [DW-1:0]    target_val,
    input  logic             flush,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [CW-1:0]    code,
    output logic             code_last,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy
);

    enc_state_t       state_q, state_d;
    logic [DW-1:0]    residual_q, residual_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;

    logic [CW-1:0]    sel_code;
    logic [DW-1:0]    sel_step;
    logic [DW-1:0]    residual_after;
    logic             last_beat;

    immed_step_sel u_step_sel (
        .residual (residual_q),
        .code     (sel_code),
        .step_val (sel_step)
    );

    assign residual_after = residual_q - sel_step;
    assign last_beat      = (residual_after == '0);
    assign step_cnt       = step_cnt_q;

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        step_cnt_d = step_cnt_q;
        in_ready   = 1'b0;
        code_valid = 1'b0;
        code       = IMM_ZERO;
        code_last  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    residual_d = target_val - base_val;
                    step_cnt_d = '0;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                code_valid = 1'b1;
                busy       = 1'b1;
                code       = sel_code;
                code_last  = last_beat;
                if (code_ready) begin
                    residual_d = residual_after;
                    step_cnt_d = step_cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
                // A beat taken in the flush cycle is still counted above.
                if (flush) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            residual_q <= '0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            step_cnt_q <= step_cnt_d;
        end
    end

endmodule

// File: tb/tb_immed_encoder.sv
// Scoreboard bench for immed_encoder: a stimulus thread pushes the reference
// code stream per request, a negedge monitor pops and compares each beat.
module tb_immed_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] base_val;
    logic [7:0] target_val;
    logic       flush;
    logic       code_valid;
    logic       code_ready;
    logic [2:0] code;
    logic       code_last;
    logic [5:0] step_cnt;
    logic       busy;

    typedef struct {
        logic [2:0] code;
        logic       last;
        int         idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_total;

    immed_encoder #(.DW(8), .CW(3), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_val   (base_val),
        .target_val (target_val),
        .flush      (flush),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .code_last  (code_last),
        .step_cnt   (step_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: signed distance, then repeatedly take the biggest allowed step toward zero.
    task automatic model_push(input logic [7:0] b, input logic [7:0] t);
        int r;
        int v;
        int n;
        logic [2:0] c;
        r = int'(t) - int'(b);
        if (r > 127)  r -= 256;
        if (r < -128) r += 256;
        n = 0;
        do begin
            if (r >= 8)       begin v = 8;  c = 3'b100; end
            else if (r >= 4)  begin v = 4;  c = 3'b011; end
            else if (r >= 2)  begin v = 2;  c = 3'b010; end
            else if (r == 1)  begin v = 1;  c = 3'b001; end
            else if (r == 0)  begin v = 0;  c = 3'b000; end
            else if (r == -1) begin v = -1; c = 3'b101; end
            else if (r >= -3) begin v = -2; c = 3'b110; end
            else              begin v = -4; c = 3'b111; end
            r -= v;
            sb_q.push_back('{code: c, last: (r == 0), idx: n});
            n++;
        end while (r != 0);
        exp_total = n;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && code_valid && code_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra_beat: got code=%b, expected no beat", code);
            end else begin
                e = sb_q.pop_front();
                check("beat_code", int'(code), int'(e.code));
                check("beat_last", int'(code_last), int'(e.last));
                check("beat_cnt", int'(step_cnt), e.idx);
                check("beat_in_ready", int'(in_ready), 0);
                $display("beat code=%b last=%0d cnt=%0d", code, code_last, step_cnt);
            end
        end
    end

    task automatic check_reset_outputs(input string nm);
        check({nm, "_code_valid"}, int'(code_valid), 0);
        check({nm, "_code"},       int'(code), 0);
        check({nm, "_code_last"},  int'(code_last), 0);
        check({nm, "_busy"},       int'(busy), 0);
        check({nm, "_in_ready"},   int'(in_ready), 1);
        check({nm, "_step_cnt"},   int'(step_cnt), 0);
    endtask

    // Called at posedge+1 with the encoder idle; request is accepted at the next edge.
    task automatic send(input logic [7:0] b, input logic [7:0] t);
        check("send_in_ready", int'(in_ready), 1);
        base_val   = b;
        target_val = t;
        in_valid   = 1'b1;
        model_push(b, t);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        $display("request base=%02h target=%02h beats=%0d", b, t, exp_total);
    endtask

    task automatic wait_idle(input string nm, input bit rand_ready, input int total);
        int cyc;
        cyc = 0;
        while ((busy || sb_q.size() != 0) && cyc < 400) begin
            code_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        check({nm, "_no_timeout"}, int'(cyc < 400), 1);
        check({nm, "_total"}, int'(step_cnt), total);
        check({nm, "_in_ready"}, int'(in_ready), 1);
        code_ready = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        base_val   = 8'h00;
        target_val = 8'h00;
        flush      = 1'b0;
        code_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(8'h00, 8'h0D);
        wait_idle("t1", 1'b0, 3);
        send(8'h0A, 8'h07);
        wait_idle("t2", 1'b0, 2);
        send(8'h55, 8'h55);
        wait_idle("t3", 1'b0, 1);
        send(8'h00, 8'h80);
        wait_idle("t4", 1'b0, 32);

        // Backpressure on beat 2 of the +127 walk.
        send(8'h00, 8'h7F);
        code_ready = 1'b1;
        @(posedge clk); #1;
        code_ready = 1'b0;
        repeat (3) begin
            check("bp_code", int'(code), 4);
            check("bp_cnt", int'(step_cnt), 1);
            check("bp_valid", int'(code_valid), 1);
            @(posedge clk); #1;
        end
        wait_idle("t5", 1'b0, 18);

        // Flush in IDLE must not disturb anything.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("idle_flush_in_ready", int'(in_ready), 1);
        check("idle_flush_valid", int'(code_valid), 0);

        // Flush on beat 3: that beat still counts.
        send(8'h00, 8'h80);
        code_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_valid", int'(code_valid), 0);
        check("flush_in_ready", int'(in_ready), 1);
        check("flush_cnt", int'(step_cnt), 3);
        sb_q.delete();

        // Reset while beat 5 is presented.
        send(8'h00, 8'h80);
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_cnt", int'(step_cnt), 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        send(8'h00, 8'h0D);
        wait_idle("after_rst", 1'b0, 3);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] b;
            logic [7:0] t;
            b = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            send(b, t);
            wait_idle("rand", 1'b1, exp_total);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
